// File: rtl/pq_if.sv
// Priority-queue request/response bundle.
//   slave  : the queue side (requests in, status/head/overflow out)
//   master : the requester side
// Requests : push_i, pop_i, drop_i, drop_id_i, data_i
// Responses: push_id_o, push/pop/drop ready, full/empty/cnt, head data,
//            peek, overflow pulse and evicted data
interface pq_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 8,
    parameter int unsigned IW    = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
);
    logic          push_i;
    logic          pop_i;
    logic          drop_i;
    logic [IW-1:0] drop_id_i;
    logic [DW-1:0] data_i;
    logic [IW-1:0] push_id_o;
    logic          push_rdy_o;
    logic          pop_rdy_o;
    logic          drop_rdy_o;
    logic          full_o;
    logic          empty_o;
    logic [CW-1:0] cnt_o;
    logic [DW-1:0] data_o;
    logic          peek_vld_o;
    logic [DW-1:0] peek_data_o;
    logic          overflow_o;
    logic [DW-1:0] data_overflow_o;

    modport slave (
        input  push_i, pop_i, drop_i, drop_id_i, data_i,
        output push_id_o, push_rdy_o, pop_rdy_o, drop_rdy_o, full_o, empty_o,
               cnt_o, data_o, peek_vld_o, peek_data_o, overflow_o, data_overflow_o
    );

    modport master (
        output push_i, pop_i, drop_i, drop_id_i, data_i,
        input  push_id_o, push_rdy_o, pop_rdy_o, drop_rdy_o, full_o, empty_o,
               cnt_o, data_o, peek_vld_o, peek_data_o, overflow_o, data_overflow_o
    );
endinterface

// File: rtl/pq.sv
// Sorted priority queue: DEPTH entries kept ascending by data, head at index 0.
// Push inserts behind equal entries, pop removes the head, drop removes every
// entry carrying a given id. A push into a full queue evicts the tail (or the
// new data itself if it is not smaller) and reports it with a one-cycle pulse.
// Ports: clk_i, rst_ni (async active-low), bus (pq_if.slave).
module pq #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DW    = 8,
    parameter int unsigned IW    = 4
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    pq_if.slave   bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [IW-1:0] id_q   [DEPTH];
    logic [IW-1:0] id_d   [DEPTH];
    logic          vld_q  [DEPTH];
    logic          vld_d  [DEPTH];
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] push_id_q, push_id_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] ovf_data_q, ovf_data_d;

    // working copies after the pop/evict stage, before insertion
    logic [DW-1:0] wd [DEPTH];
    logic [IW-1:0] wi [DEPTH];
    logic          wv [DEPTH];
    int unsigned   n_w, pos_w, kept_w;
    int unsigned   rank_w [DEPTH];
    logic          surv_w [DEPTH];
    logic          ins_w;

    logic empty_c, pop_acc_c, push_acc_c;

    assign empty_c    = (cnt_q == '0);
    assign pop_acc_c  = bus.pop_i && !empty_c && !bus.drop_i;
    assign push_acc_c = bus.push_i && !bus.drop_i;

    // next-state: drop compaction, or pop followed by sorted insert
    always_comb begin
        data_d     = data_q;
        id_d       = id_q;
        vld_d      = vld_q;
        cnt_d      = cnt_q;
        push_id_d  = push_id_q;
        ovf_d      = 1'b0;
        ovf_data_d = ovf_data_q;
        wd         = data_q;
        wi         = id_q;
        wv         = vld_q;
        n_w        = 32'(cnt_q);
        pos_w      = 0;
        kept_w     = 0;
        ins_w      = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            surv_w[i] = vld_q[i] && (id_q[i] != bus.drop_id_i);
            rank_w[i] = kept_w;
            if (surv_w[i]) kept_w = kept_w + 1;
        end

        if (bus.drop_i) begin
            // survivor with rank j moves to slot j, order preserved
            for (int unsigned j = 0; j < DEPTH; j++) begin
                data_d[j] = '0;
                id_d[j]   = '0;
                vld_d[j]  = 1'b0;
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (surv_w[i] && rank_w[i] == j) begin
                        data_d[j] = data_q[i];
                        id_d[j]   = id_q[i];
                        vld_d[j]  = 1'b1;
                    end
                end
            end
            cnt_d = CW'(kept_w);
        end else begin
            if (pop_acc_c) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    wd[i] = wd[i+1];
                    wi[i] = wi[i+1];
                    wv[i] = wv[i+1];
                end
                wd[DEPTH-1] = '0;
                wi[DEPTH-1] = '0;
                wv[DEPTH-1] = 1'b0;
                n_w         = n_w - 1;
            end
            if (push_acc_c) begin
                push_id_d = push_id_q + IW'(1);
                ins_w     = 1'b1;
                if (n_w == DEPTH) begin
                    ovf_d = 1'b1;
                    if (bus.data_i < wd[DEPTH-1]) begin
                        ovf_data_d  = wd[DEPTH-1];
                        wd[DEPTH-1] = '0;
                        wi[DEPTH-1] = '0;
                        wv[DEPTH-1] = 1'b0;
                        n_w         = DEPTH - 1;
                    end else begin
                        ovf_data_d = bus.data_i;
                        ins_w      = 1'b0;
                    end
                end
            end
            data_d = wd;
            id_d   = wi;
            vld_d  = wv;
            if (ins_w) begin
                // insert after every entry <= data_i so ties stay FIFO
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (i < n_w && wd[i] <= bus.data_i) pos_w = pos_w + 1;
                end
                if (pos_w == 0) begin
                    data_d[0] = bus.data_i;
                    id_d[0]   = push_id_q;
                    vld_d[0]  = 1'b1;
                end
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    if (i == pos_w) begin
                        data_d[i] = bus.data_i;
                        id_d[i]   = push_id_q;
                        vld_d[i]  = 1'b1;
                    end else if (i > pos_w) begin
                        data_d[i] = wd[i-1];
                        id_d[i]   = wi[i-1];
                        vld_d[i]  = wv[i-1];
                    end
                end
                n_w = n_w + 1;
            end
            cnt_d = CW'(n_w);
        end
    end

    // state registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
                id_q[i]   <= '0;
                vld_q[i]  <= 1'b0;
            end
            cnt_q      <= '0;
            push_id_q  <= '0;
            ovf_q      <= 1'b0;
            ovf_data_q <= '0;
        end else begin
            data_q     <= data_d;
            id_q       <= id_d;
            vld_q      <= vld_d;
            cnt_q      <= cnt_d;
            push_id_q  <= push_id_d;
            ovf_q      <= ovf_d;
            ovf_data_q <= ovf_data_d;
        end
    end

    assign bus.push_id_o       = push_id_q;
    assign bus.drop_rdy_o      = 1'b1;
    assign bus.pop_rdy_o       = !empty_c && !bus.drop_i;
    assign bus.push_rdy_o      = !bus.drop_i;
    assign bus.full_o          = (cnt_q == CW'(DEPTH));
    assign bus.empty_o         = empty_c;
    assign bus.cnt_o           = cnt_q;
    assign bus.data_o          = empty_c ? '0 : data_q[0];
    assign bus.peek_data_o     = empty_c ? '0 : data_q[0];
    assign bus.peek_vld_o      = !empty_c;
    assign bus.overflow_o      = ovf_q;
    assign bus.data_overflow_o = ovf_data_q;
endmodule

// File: tb/tb_pq.sv
// Self-checking bench for pq: directed table, reset corner, randomized run
// against a queue-based reference model.
module tb_pq;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned IW    = 4;

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    pq_if #(.DEPTH(DEPTH), .DW(DW), .IW(IW)) bus ();
    pq #(.DEPTH(DEPTH), .DW(DW), .IW(IW)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          push;
        logic          pop;
        logic          drop;
        logic [IW-1:0] did;
        logic [DW-1:0] din;
        logic [DW-1:0] e_head;
        int            e_cnt;
        logic [IW-1:0] e_id;
        logic          e_ovf;
        logic [DW-1:0] e_od;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic [IW-1:0] id;
    } ent_t;

    vec_t vecs[$];
    ent_t m_q[$];
    logic [IW-1:0] m_id;
    logic          m_ovf;
    logic [DW-1:0] m_od;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_state(input string tag, input logic [DW-1:0] head, input int cnt,
                               input logic [IW-1:0] id, input logic ovf, input logic [DW-1:0] od);
        chk({tag, " cnt"}, 32'(bus.cnt_o), 32'(cnt));
        chk({tag, " data_o"}, 32'(bus.data_o), 32'(head));
        chk({tag, " peek_data"}, 32'(bus.peek_data_o), 32'(head));
        chk({tag, " peek_vld"}, 32'(bus.peek_vld_o), 32'(cnt != 0));
        chk({tag, " empty"}, 32'(bus.empty_o), 32'(cnt == 0));
        chk({tag, " full"}, 32'(bus.full_o), 32'(cnt == DEPTH));
        chk({tag, " push_id"}, 32'(bus.push_id_o), 32'(id));
        chk({tag, " overflow"}, 32'(bus.overflow_o), 32'(ovf));
        chk({tag, " ovf_data"}, 32'(bus.data_overflow_o), 32'(od));
    endtask

    task automatic add(input logic pu, input logic po, input logic dr, input logic [IW-1:0] did,
                       input logic [DW-1:0] din, input logic [DW-1:0] h, input int c,
                       input logic [IW-1:0] id, input logic ov, input logic [DW-1:0] od);
        vec_t v;
        v.push = pu; v.pop = po; v.drop = dr; v.did = did; v.din = din;
        v.e_head = h; v.e_cnt = c; v.e_id = id; v.e_ovf = ov; v.e_od = od;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic pu, input logic po, input logic dr,
                         input logic [IW-1:0] did, input logic [DW-1:0] din);
        bus.push_i = pu; bus.pop_i = po; bus.drop_i = dr;
        bus.drop_id_i = did; bus.data_i = din;
    endtask

    // reference model: ordered list, ties resolved by arrival order
    task automatic m_insert(input ent_t e);
        int pos = m_q.size();
        for (int i = 0; i < m_q.size(); i++) begin
            if (m_q[i].d > e.d) begin
                pos = i;
                break;
            end
        end
        m_q.insert(pos, e);
    endtask

    task automatic model_step(input logic pu, input logic po, input logic dr,
                              input logic [IW-1:0] did, input logic [DW-1:0] din);
        ent_t e;
        ent_t nq[$];
        m_ovf = 1'b0;
        if (dr) begin
            foreach (m_q[i]) if (m_q[i].id != did) nq.push_back(m_q[i]);
            m_q = nq;
        end else begin
            if (po && m_q.size() > 0) void'(m_q.pop_front());
            if (pu) begin
                e.d = din;
                e.id = m_id;
                m_id = m_id + 1'b1;
                if (m_q.size() < DEPTH) begin
                    m_insert(e);
                end else begin
                    m_ovf = 1'b1;
                    if (din < m_q[m_q.size()-1].d) begin
                        m_od = m_q[m_q.size()-1].d;
                        void'(m_q.pop_back());
                        m_insert(e);
                    end else begin
                        m_od = din;
                    end
                end
            end
        end
    endtask

    initial begin
        logic pu, po, dr;
        logic [IW-1:0] did;
        logic [DW-1:0] din;
        logic [DW-1:0] h;

        // directed table: inputs, then state expected after the edge
        add(1,0,0,0,8'hF0, 8'hF0,1,1,0,0);
        add(1,0,0,0,8'h15, 8'h15,2,2,0,0);
        add(1,0,0,0,8'h87, 8'h15,3,3,0,0);
        add(0,1,0,0,8'h00, 8'h87,2,3,0,0);
        add(0,1,0,0,8'h00, 8'hF0,1,3,0,0);
        add(0,1,0,0,8'h00, 8'h00,0,3,0,0);
        add(1,0,0,0,8'h01, 8'h01,1,4,0,0);
        add(1,0,0,0,8'hEB, 8'h01,2,5,0,0);
        add(1,0,0,0,8'hAF, 8'h01,3,6,0,0);
        add(0,1,0,0,8'h00, 8'hAF,2,6,0,0);
        add(0,0,1,3,8'h00, 8'hAF,2,6,0,0);
        add(0,1,0,0,8'h00, 8'hEB,1,6,0,0);
        add(0,1,0,0,8'h00, 8'h00,0,6,0,0);
        add(1,0,0,0,8'h01, 8'h01,1,7,0,0);
        add(1,0,0,0,8'h11, 8'h01,2,8,0,0);
        add(1,0,0,0,8'h12, 8'h01,3,9,0,0);
        add(0,1,0,0,8'h00, 8'h11,2,9,0,0);
        add(1,0,0,0,8'h13, 8'h11,3,10,0,0);
        add(0,1,0,0,8'h00, 8'h12,2,10,0,0);
        add(0,1,0,0,8'h00, 8'h13,1,10,0,0);
        add(0,1,0,0,8'h00, 8'h00,0,10,0,0);
        for (int i = 0; i < 8; i++) add(1,0,0,0,8'h10, 8'h10,i+1,IW'(11+i),0,0);
        add(1,0,0,0,8'h05, 8'h05,8,3,1,8'h10);
        add(1,0,0,0,8'h20, 8'h05,8,4,1,8'h20);
        add(0,0,0,0,8'h00, 8'h05,8,4,0,8'h20);
        add(1,1,0,0,8'h07, 8'h07,8,5,0,8'h20);
        add(0,0,1,4,8'h00, 8'h10,7,5,0,8'h20);
        add(0,0,1,10,8'h00, 8'h10,6,5,0,8'h20);
        add(1,0,1,11,8'h01, 8'h10,5,5,0,8'h20);
        add(0,1,0,0,8'h00, 8'h10,4,5,0,8'h20);

        drive(0,0,0,0,0);
        rst_n = 1'b0;
        #12;
        check_state("reset", 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].push, vecs[k].pop, vecs[k].drop, vecs[k].did, vecs[k].din);
            @(posedge clk);
            #1;
            check_state($sformatf("vec%0d", k), vecs[k].e_head, vecs[k].e_cnt,
                        vecs[k].e_id, vecs[k].e_ovf, vecs[k].e_od);
        end

        // reset asserted while a push is being presented
        @(negedge clk);
        drive(0,1,0,0,0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(1,0,0,0,DW'(8'h30 + i));
            @(negedge clk);
        end
        drive(1,0,0,0,8'h44);
        #2;
        rst_n = 1'b0;
        #1;
        check_state("midreset", 8'h00, 0, 0, 0, 0);
        @(negedge clk);
        drive(0,0,0,0,0);
        rst_n = 1'b1;
        m_q.delete();
        m_id = '0;
        m_ovf = 1'b0;
        m_od = '0;

        // randomized run against the reference model
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            pu  = ($urandom_range(0, 99) < 55);
            po  = ($urandom_range(0, 99) < 40);
            dr  = ($urandom_range(0, 99) < 7);
            did = IW'($urandom_range(0, 15));
            din = DW'($urandom_range(0, 31));
            drive(pu, po, dr, did, din);
            #1;
            chk("push_rdy", 32'(bus.push_rdy_o), 32'(!dr));
            chk("pop_rdy", 32'(bus.pop_rdy_o), 32'(m_q.size() > 0 && !dr));
            chk("drop_rdy", 32'(bus.drop_rdy_o), 32'(1));
            @(posedge clk);
            model_step(pu, po, dr, did, din);
            #1;
            h = (m_q.size() > 0) ? m_q[0].d : '0;
            check_state($sformatf("rand%0d", c), h, m_q.size(), m_id, m_ovf, m_od);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
